// File: rtl/multicycle_sequencer.sv
// Control FSM for the multi-cycle RISC-V datapath: fetch/decode/exec/mem/wb with a memory-wait timeout.
// Outputs are decoded from the registered state; instructions retire 3-5 cycles after FETCH plus memory waits.
module multicycle_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_src_b,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic [2:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, legal;
    logic timed_out;
    logic [2:0] after_retire;

    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign legal   = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr;

    // ready in the same cycle the counter sits at TIMEOUT still counts as progress
    assign timed_out    = (wait_q == 8'(TIMEOUT));
    assign after_retire = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timed_out) state_d = S_FAULT;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                if (is_ld || is_st)                      state_d = S_MEM;
                else if (is_br)                          state_d = after_retire;
                else if (is_r || is_i || is_jal || is_jalr) state_d = S_WB;
                else                                     state_d = S_FAULT;
            end
            S_MEM: begin
                if (mem_ready)      state_d = is_st ? after_retire : S_WB;
                else if (timed_out) state_d = S_FAULT;
            end
            S_WB:     state_d = after_retire;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase

        if (state_d != state_q)       wait_d = 8'd0;
        else if (mem_req && !mem_ready) wait_d = wait_q + 8'd1;
        else                          wait_d = wait_q;

        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        alu_src_b = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        retire    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_EXEC: begin
                alu_src_b = !(is_r || is_br);
                if (is_br) begin
                    pc_we  = branch_taken;
                    pc_sel = 2'b01;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = is_st;
                alu_src_b = 1'b1;
                retire    = is_st && mem_ready;
            end
            S_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
                if (is_ld) begin
                    wb_sel = 2'b01;
                end else if (is_jal || is_jalr) begin
                    wb_sel = 2'b10;
                    pc_we  = 1'b1;
                    pc_sel = 2'b10;
                end
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign state_o     = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with hand-computed per-cycle state and control vectors.
module tb_multicycle_sequencer;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic       clk = 1'b0;
    logic       reset, run, branch_taken, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, alu_src_b, reg_we, retire, fault;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state_o;
    logic [3:0] instr_count;
    logic [12:0] ctl_w;

    int total = 0;
    int bad   = 0;
    int k;

    always #5 clk = ~clk;

    multicycle_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_b(alu_src_b), .reg_we(reg_we),
        .wb_sel(wb_sel), .retire(retire), .fault(fault), .state_o(state_o),
        .instr_count(instr_count)
    );

    // {mem_req,mem_we,addr_sel,ir_we,pc_we,pc_sel,alu_src_b,reg_we,wb_sel,retire,fault}
    assign ctl_w = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel,
                    alu_src_b, reg_we, wb_sel, retire, fault};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cyc(input string tag, input logic [2:0] st, input logic [12:0] c);
        #1;
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl_w), 32'(c));
    endtask

    logic [6:0]  ops [3] = '{OP_JAL, OP_JALR, OP_I};
    logic [12:0] wbx [3] = '{13'h19A, 13'h19A, 13'h012};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; opcode = OP_R; branch_taken = 1'b0; mem_ready = 1'b1;
        nx(); nx();
        exp_cyc("rst", 3'd0, 13'h0);
        chk("rst.cnt", 32'(instr_count), 0);
        reset = 1'b0; run = 1'b1;
        exp_cyc("idle", 3'd0, 13'h0);

        // R-type, zero-wait memory
        nx(); exp_cyc("r.fetch", 3'd1, 13'h1300);
        nx(); exp_cyc("r.dec",   3'd2, 13'h0);
        nx(); exp_cyc("r.exec",  3'd3, 13'h0);
        nx(); exp_cyc("r.wb",    3'd5, 13'h012);

        // LOAD with 3 wait cycles in FETCH and MEM
        nx(); opcode = OP_LD; mem_ready = 1'b0; k = 1;
        exp_cyc("ld.f0", 3'd1, 13'h1000);
        chk("r.cnt", 32'(instr_count), 1);
        for (int i = 0; i < 2; i++) begin nx(); k++; exp_cyc("ld.fw", 3'd1, 13'h1000); end
        nx(); k++; mem_ready = 1'b1; exp_cyc("ld.frdy", 3'd1, 13'h1300);
        nx(); k++; exp_cyc("ld.dec", 3'd2, 13'h0);
        nx(); k++; exp_cyc("ld.exec", 3'd3, 13'h020);
        nx(); k++; mem_ready = 1'b0; exp_cyc("ld.m0", 3'd4, 13'h1420);
        for (int i = 0; i < 2; i++) begin nx(); k++; exp_cyc("ld.mw", 3'd4, 13'h1420); end
        nx(); k++; mem_ready = 1'b1; exp_cyc("ld.mrdy", 3'd4, 13'h1420);
        nx(); k++; exp_cyc("ld.wb", 3'd5, 13'h016);
        chk("ld.lat", 32'(k), 11);

        // BRANCH taken then not taken
        nx(); opcode = OP_BR; branch_taken = 1'b1;
        exp_cyc("bt.fetch", 3'd1, 13'h1300);
        chk("ld.cnt", 32'(instr_count), 2);
        nx(); exp_cyc("bt.dec", 3'd2, 13'h0);
        nx(); exp_cyc("bt.exec", 3'd3, 13'h142);
        nx(); branch_taken = 1'b0;
        exp_cyc("bn.fetch", 3'd1, 13'h1300);
        chk("bt.cnt", 32'(instr_count), 3);
        nx(); exp_cyc("bn.dec", 3'd2, 13'h0);
        nx(); exp_cyc("bn.exec", 3'd3, 13'h042);

        // STORE retiring with run=0, then parked in IDLE
        nx(); opcode = OP_ST;
        exp_cyc("st.fetch", 3'd1, 13'h1300);
        chk("bn.cnt", 32'(instr_count), 4);
        nx(); exp_cyc("st.dec", 3'd2, 13'h0);
        nx(); exp_cyc("st.exec", 3'd3, 13'h020);
        nx(); run = 1'b0; exp_cyc("st.mem", 3'd4, 13'h1C22);
        for (int i = 0; i < 3; i++) begin nx(); exp_cyc("st.idle", 3'd0, 13'h0); end
        chk("st.cnt", 32'(instr_count), 5);
        run = 1'b1;

        // JAL, JALR, I-ALU
        for (int j = 0; j < 3; j++) begin
            nx(); opcode = ops[j];
            exp_cyc("x.fetch", 3'd1, 13'h1300);
            nx(); exp_cyc("x.dec", 3'd2, 13'h0);
            nx(); exp_cyc("x.exec", 3'd3, 13'h020);
            nx(); exp_cyc("x.wb", 3'd5, wbx[j]);
        end

        // ready on the cycle the wait counter reaches TIMEOUT: no fault
        nx(); opcode = OP_R; mem_ready = 1'b0;
        chk("x.cnt", 32'(instr_count), 8);
        for (int i = 0; i < 15; i++) begin
            exp_cyc("tv.wait", 3'd1, 13'h1000);
            nx();
        end
        mem_ready = 1'b1;
        exp_cyc("tv.rdy", 3'd1, 13'h1300);
        nx(); exp_cyc("tv.dec", 3'd2, 13'h0);
        nx(); nx(); exp_cyc("tv.wb", 3'd5, 13'h012);

        // instr_count wraps at 4 bits
        opcode = OP_BR;
        for (int j = 0; j < 7; j++) begin
            nx(); exp_cyc("w.fetch", 3'd1, 13'h1300);
            chk("w.cnt", 32'(instr_count), 32'((9 + j) % 16));
            nx(); nx(); exp_cyc("w.exec", 3'd3, 13'h042);
        end
        nx();
        chk("wrap.cnt", 32'(instr_count), 0);

        // illegal opcode -> sticky FAULT
        opcode = 7'b1111111;
        exp_cyc("il.fetch", 3'd1, 13'h1300);
        nx(); exp_cyc("il.dec", 3'd2, 13'h0);
        for (int i = 0; i < 20; i++) begin nx(); exp_cyc("il.fault", 3'd7, 13'h001); end
        reset = 1'b1;
        nx(); reset = 1'b0;
        exp_cyc("il.rst", 3'd0, 13'h0);
        chk("il.cnt", 32'(instr_count), 0);

        // memory never ready in FETCH -> FAULT
        nx(); opcode = OP_R; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_cyc("to.wait", 3'd1, 13'h1000);
            nx();
        end
        exp_cyc("to.fault", 3'd7, 13'h001);

        // reset while a MEM request is outstanding
        reset = 1'b1;
        nx(); reset = 1'b0; mem_ready = 1'b1; opcode = OP_LD;
        exp_cyc("rm.idle", 3'd0, 13'h0);
        nx(); nx(); nx(); nx(); mem_ready = 1'b0;
        exp_cyc("rm.mem", 3'd4, 13'h1420);
        reset = 1'b1;
        nx(); reset = 1'b0;
        exp_cyc("rm.rst", 3'd0, 13'h0);
        nx(); exp_cyc("rm.refetch", 3'd1, 13'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
